mmio_initiator: RTL and testbench

//  Bus-master end of the MMIO request/ready interface. Accepts CPU-native requests
//  (valid/addr/wdata/wstrb) already decoded to the 0x8000_0000 region, then drives

---
 rtl/mmio_initiator_if.sv | 20 ++
 rtl/mmio_initiator.sv | 94 +++++++++
 tb/tb_mmio_initiator.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_initiator_if.sv
// rtl/mmio_initiator_if.sv - MMIO request/ready bus between initiator and peripheral block
interface mmio_initiator_if;
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output valid, write, addr, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, write, addr, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/mmio_initiator.sv
// rtl/mmio_initiator.sv - MMIO bus master with one-cycle gap and timeout watchdog
module mmio_initiator #(
    parameter int          TIMEOUT_CYCLES = 65536,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEADBEEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                cpu_valid,
    input  logic [31:0]         cpu_addr,
    input  logic [31:0]         cpu_wdata,
    input  logic [3:0]          cpu_wstrb,
    output logic [31:0]         cpu_rdata,
    output logic                cpu_ready,
    mmio_initiator_if.master    mmio,
    output logic                timeout_err,
    output logic [31:0]         timeout_addr,
    input  logic                err_clear
);
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;

    // Request sequencer: accept in IDLE, hold bus in REQ until ack or timeout, one idle cycle in GAP.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            cpu_rdata    <= '0;
            cpu_ready    <= 1'b0;
            mmio.valid   <= 1'b0;
            mmio.write   <= 1'b0;
            mmio.addr    <= '0;
            mmio.wdata   <= '0;
            mmio.wstrb   <= '0;
            timeout_err  <= 1'b0;
            timeout_addr <= '0;
        end else begin
            // Clear first so a timeout recorded later in this same cycle takes precedence.
            if (err_clear) begin
                timeout_err <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    cpu_ready <= 1'b0;
                    if (cpu_valid) begin
                        mmio.addr  <= cpu_addr;
                        mmio.wdata <= cpu_wdata;
                        mmio.wstrb <= cpu_wstrb;
                        mmio.write <= |cpu_wstrb;
                        mmio.valid <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // A real ack always beats the watchdog, even on the final cycle.
                    if (mmio.ready) begin
                        mmio.valid <= 1'b0;
                        cpu_rdata  <= mmio.rdata;
                        cpu_ready  <= 1'b1;
                        state      <= ST_GAP;
                    end else if (wait_cnt == CNT_LAST) begin
                        mmio.valid   <= 1'b0;
                        cpu_rdata    <= TIMEOUT_RDATA;
                        cpu_ready    <= 1'b1;
                        timeout_err  <= 1'b1;
                        timeout_addr <= mmio.addr;
                        state        <= ST_GAP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    // Responder re-acks while valid is high, so valid must drop for a cycle.
                    cpu_ready <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    cpu_ready  <= 1'b0;
                    mmio.valid <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_initiator.sv
// tb/tb_mmio_initiator.sv - self-checking bench for mmio_initiator
module tb_mmio_initiator;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    // Index 0: default watchdog; index 1: TIMEOUT_CYCLES=16.
    logic        cpu_valid [2];
    logic [31:0] cpu_addr  [2];
    logic [31:0] cpu_wdata [2];
    logic [3:0]  cpu_wstrb [2];
    logic        err_clear [2];
    logic        mready    [2];
    logic [31:0] mrdata    [2];

    logic [31:0] dut_rdata [2];
    logic        dut_ready [2];
    logic        terr      [2];
    logic [31:0] taddr     [2];
    logic        mv        [2];
    logic        mw        [2];
    logic [31:0] ma        [2];
    logic [31:0] mwd       [2];
    logic [3:0]  mws       [2];

    mmio_initiator_if bus0 ();
    mmio_initiator_if bus1 ();

    assign bus0.ready = mready[0];
    assign bus0.rdata = mrdata[0];
    assign bus1.ready = mready[1];
    assign bus1.rdata = mrdata[1];
    assign mv[0] = bus0.valid;  assign mv[1] = bus1.valid;
    assign mw[0] = bus0.write;  assign mw[1] = bus1.write;
    assign ma[0] = bus0.addr;   assign ma[1] = bus1.addr;
    assign mwd[0] = bus0.wdata; assign mwd[1] = bus1.wdata;
    assign mws[0] = bus0.wstrb; assign mws[1] = bus1.wstrb;

    mmio_initiator u_dut (
        .clk(clk), .resetn(resetn),
        .cpu_valid(cpu_valid[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
        .cpu_wstrb(cpu_wstrb[0]), .cpu_rdata(dut_rdata[0]), .cpu_ready(dut_ready[0]),
        .mmio(bus0.master), .timeout_err(terr[0]), .timeout_addr(taddr[0]),
        .err_clear(err_clear[0])
    );

    mmio_initiator #(.TIMEOUT_CYCLES(16)) u_dut16 (
        .clk(clk), .resetn(resetn),
        .cpu_valid(cpu_valid[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
        .cpu_wstrb(cpu_wstrb[1]), .cpu_rdata(dut_rdata[1]), .cpu_ready(dut_ready[1]),
        .mmio(bus1.master), .timeout_err(terr[1]), .timeout_addr(taddr[1]),
        .err_clear(err_clear[1])
    );

    int checks = 0;
    int fails  = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one CPU access and plays a peripheral that acks dly cycles after first seeing valid
    // (dly<0: never acks). All observation happens on the falling edge.
    task automatic do_access(input int s, input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws, input int dly, input logic [31:0] ad,
                             output logic [31:0] rd, output int rcnt, output int vc,
                             output int lat, output bit stable);
        int  seen = 0;
        int  k = 0;
        bit  done = 0;
        rd = '0; rcnt = 0; vc = 0; lat = -1; stable = 1'b1;
        @(negedge clk);
        cpu_valid[s] = 1'b1; cpu_addr[s] = a; cpu_wdata[s] = wd; cpu_wstrb[s] = ws;
        while (!done && k < 1000) begin
            @(negedge clk);
            k++;
            mready[s] = 1'b0;
            if (dut_ready[s]) begin
                rcnt++;
                rd = dut_rdata[s];
                if (lat < 0) lat = k;
                cpu_valid[s] = 1'b0;
            end
            if (mv[s]) begin
                vc++;
                if (ma[s] !== a || mwd[s] !== wd || mws[s] !== ws || mw[s] !== (|ws))
                    stable = 1'b0;
                if (dly >= 0 && seen == dly) begin
                    mready[s] = 1'b1;
                    mrdata[s] = ad;
                end
                seen++;
            end
            if (lat >= 0 && k >= lat + 2) done = 1'b1;
        end
        if (!done) begin
            checks++;
            fails++;
            $display("FAIL access_bound: no cpu_ready within 1000 cycles, addr 0x%08h", a);
        end
        mready[s] = 1'b0;
        cpu_valid[s] = 1'b0;
    endtask

    typedef struct {
        int          s;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          dly;
        logic [31:0] ack_data;
        logic [31:0] exp_rdata;
        int          exp_vc;
        int          exp_lat;
        logic        exp_err;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [31:0] rd;
        int          rcnt, vc, lat;
        bit          stable;

        vecs[0] = '{0, 32'h8000_0010, 32'h0,         4'h0, 0,   32'h0000_0003, 32'h0000_0003, 1,   2,   1'b0};
        vecs[1] = '{0, 32'h8000_0000, 32'h0000_0041, 4'h1, 500, 32'h1234_5678, 32'h1234_5678, 501, 502, 1'b0};
        vecs[2] = '{0, 32'h8000_0008, 32'hCAFE_F00D, 4'hF, 3,   32'h0,         32'h0,         4,   5,   1'b0};
        vecs[3] = '{1, 32'h8000_0020, 32'h0,         4'h0, 15,  32'hA5A5_0001, 32'hA5A5_0001, 16,  17,  1'b0};
        vecs[4] = '{1, 32'h8000_0024, 32'h0,         4'h0, 14,  32'h0000_0077, 32'h0000_0077, 15,  16,  1'b0};
        vecs[5] = '{1, 32'h8000_0030, 32'h1111_2222, 4'h6, -1,  32'h0,         32'hDEAD_BEEF, 16,  17,  1'b1};

        for (int i = 0; i < 2; i++) begin
            cpu_valid[i] = 1'b0; cpu_addr[i] = '0; cpu_wdata[i] = '0; cpu_wstrb[i] = '0;
            err_clear[i] = 1'b0; mready[i] = 1'b0; mrdata[i] = '0;
        end

        // Reset state
        #1;
        check32("reset_mmio_valid", {31'b0, mv[0]}, 32'h0);
        check32("reset_cpu_ready", {31'b0, dut_ready[0]}, 32'h0);
        check32("reset_cpu_rdata", dut_rdata[0], 32'h0);
        check32("reset_timeout_err", {31'b0, terr[1]}, 32'h0);
        check32("reset_timeout_addr", taddr[1], 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;

        // Table-driven accesses
        for (int i = 0; i < 6; i++) begin
            do_access(vecs[i].s, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].dly,
                      vecs[i].ack_data, rd, rcnt, vc, lat, stable);
            check32($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check32($sformatf("v%0d_ready_pulses", i), 32'(rcnt), 32'd1);
            check32($sformatf("v%0d_valid_cycles", i), 32'(vc), 32'(vecs[i].exp_vc));
            check32($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check32($sformatf("v%0d_bus_stable", i), {31'b0, stable}, 32'd1);
            check32($sformatf("v%0d_timeout_err", i), {31'b0, terr[vecs[i].s]}, {31'b0, vecs[i].exp_err});
        end
        check32("timeout_addr", taddr[1], 32'h8000_0030);
        check32("no_err_default_dut", {31'b0, terr[0]}, 32'h0);

        // err_clear clears the flag but keeps the address
        @(negedge clk); err_clear[1] = 1'b1;
        @(negedge clk); err_clear[1] = 1'b0;
        check32("err_clear_flag", {31'b0, terr[1]}, 32'h0);
        check32("err_clear_keeps_addr", taddr[1], 32'h8000_0030);

        // Clear asserted on the timeout cycle: the new timeout must win
        @(negedge clk);
        cpu_valid[1] = 1'b1; cpu_addr[1] = 32'h8000_0040; cpu_wstrb[1] = 4'h0;
        repeat (16) @(negedge clk);
        err_clear[1] = 1'b1;
        @(negedge clk);
        err_clear[1] = 1'b0;
        cpu_valid[1] = 1'b0;
        check32("setwins_cpu_ready", {31'b0, dut_ready[1]}, 32'h1);
        check32("setwins_timeout_err", {31'b0, terr[1]}, 32'h1);
        check32("setwins_timeout_addr", taddr[1], 32'h8000_0040);
        repeat (2) @(negedge clk);

        // Stale ack while idle is ignored
        mready[0] = 1'b1; mrdata[0] = 32'hBAD0_BAD0;
        @(negedge clk); mready[0] = 1'b0;
        check32("stale_ack_valid", {31'b0, mv[0]}, 32'h0);
        check32("stale_ack_ready", {31'b0, dut_ready[0]}, 32'h0);
        @(negedge clk);
        check32("stale_ack_ready2", {31'b0, dut_ready[0]}, 32'h0);

        // Back-to-back reads: CPU re-requests the moment the first completes
        begin
            int nreq = 0, nresp = 0, gap = 0, min_gap = 1000;
            bit prev_v = 1'b0;
            logic [31:0] r1 = '0, r2 = '0, a2seen = '0;
            @(negedge clk);
            cpu_valid[0] = 1'b1; cpu_addr[0] = 32'h8000_0100; cpu_wstrb[0] = 4'h0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                mready[0] = 1'b0;
                if (dut_ready[0]) begin
                    nresp++;
                    if (nresp == 1) begin r1 = dut_rdata[0]; cpu_addr[0] = 32'h8000_0104; end
                    else begin r2 = dut_rdata[0]; cpu_valid[0] = 1'b0; end
                end
                if (mv[0]) begin
                    if (!prev_v) begin
                        nreq++;
                        if (nreq == 2) begin
                            a2seen = ma[0];
                            if (gap < min_gap) min_gap = gap;
                        end
                    end
                    mready[0] = 1'b1;
                    mrdata[0] = (nreq == 1) ? 32'h0000_0111 : 32'h0000_0222;
                end else if (nreq >= 1) begin
                    gap++;
                end
                prev_v = mv[0];
            end
            cpu_valid[0] = 1'b0;
            check32("b2b_requests", 32'(nreq), 32'd2);
            check32("b2b_responses", 32'(nresp), 32'd2);
            check32("b2b_gap_ge1", {31'b0, (min_gap >= 1 && min_gap < 1000)}, 32'h1);
            check32("b2b_rdata1", r1, 32'h0000_0111);
            check32("b2b_rdata2", r2, 32'h0000_0222);
            check32("b2b_addr2", a2seen, 32'h8000_0104);
        end

        // Reset mid-REQ
        @(negedge clk);
        cpu_valid[0] = 1'b1; cpu_addr[0] = 32'h8000_0200; cpu_wstrb[0] = 4'h0;
        @(negedge clk);
        check32("midreq_valid_before", {31'b0, mv[0]}, 32'h1);
        #2 resetn = 1'b0;
        #1;
        check32("midreq_valid_async", {31'b0, mv[0]}, 32'h0);
        check32("midreq_ready_async", {31'b0, dut_ready[0]}, 32'h0);
        check32("midreq_addr_async", ma[0], 32'h0);
        check32("midreq_taddr_async", taddr[1], 32'h0);
        check32("midreq_terr_async", {31'b0, terr[1]}, 32'h0);
        cpu_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        do_access(0, 32'h8000_0010, 32'h0, 4'h0, 0, 32'h0000_0055, rd, rcnt, vc, lat, stable);
        check32("post_reset_rdata", rd, 32'h0000_0055);
        check32("post_reset_pulses", 32'(rcnt), 32'd1);
        check32("post_reset_latency", 32'(lat), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
